// File: rtl/dpram_xfer_arbiter.sv
// Round-robin owner arbitration for a shared host-readout DPRAM, with ready/done buffer handoff.
// Optional host-phase watchdog: define DPRAM_XFER_ARBITER_TIMEOUT_EN.
module dpram_xfer_arbiter #(
    parameter int unsigned N_REQ             = 2,
    parameter int unsigned P_DPRAM_ADR_WIDTH = 10,
    parameter int unsigned P_SRC_WIDTH       = 4,
    parameter int unsigned P_TIMEOUT         = 1048576
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             en,
    input  logic [N_REQ-1:0]                 req_want,
    input  logic [N_REQ-1:0]                 req_lock,
    input  logic [N_REQ-1:0]                 req_run,
    input  logic [N_REQ*16-1:0]              req_len,
    input  logic [N_REQ-1:0]                 req_wren,
    input  logic [N_REQ*P_DPRAM_ADR_WIDTH-1:0] req_addr,
    input  logic [N_REQ*32-1:0]              req_data,
    output logic [N_REQ-1:0]                 req_busy,
    output logic [N_REQ-1:0]                 grant,
    output logic                             dpram_wren,
    output logic [P_DPRAM_ADR_WIDTH-1:0]     dpram_addr,
    output logic [31:0]                      dpram_data,
    output logic                             dpram_ready,
    output logic [15:0]                      dpram_len,
    output logic [P_SRC_WIDTH-1:0]           dpram_src,
    input  logic                             dpram_done,
    output logic                             err_wr_drop,
    output logic                             host_timeout
);

    localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {StIdle, StFill, StHost, StRelease} state_e;

    state_e                         state_q;
    logic [IdxW-1:0]                rr_q;
    logic [IdxW-1:0]                own_q;
    logic                           wrote_q;
    logic [N_REQ-1:0]               grant_q;
    logic [N_REQ-1:0]               busy_q;
    logic                           wren_q;
    logic [P_DPRAM_ADR_WIDTH-1:0]   addr_q;
    logic [31:0]                    data_q;
    logic                           ready_q;
    logic [15:0]                    len_q;
    logic [P_SRC_WIDTH-1:0]         src_q;
    logic                           err_q;

    int unsigned                    rr_i;
    int unsigned                    own_i;
    int unsigned                    cand;
    logic                           hit;
    logic [IdxW-1:0]                hit_idx;
    logic [N_REQ-1:0]               hit_mask;
    logic [N_REQ-1:0]               own_mask;

    logic                           own_want;
    logic                           own_lock;
    logic                           own_run;
    logic                           own_wren;
    logic [15:0]                    own_len;
    logic [P_DPRAM_ADR_WIDTH-1:0]   own_addr;
    logic [31:0]                    own_data;
    logic                           fwd;
    logic                           wr_drop;

    assign rr_i  = 32'(rr_q);
    assign own_i = 32'(own_q);

    // Search starts one past the last owner so every requester gets a turn.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        cand    = 0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = (rr_i + i) % N_REQ;
            if (!hit && req_want[cand]) begin
                hit     = 1'b1;
                hit_idx = IdxW'(cand);
            end
        end
    end

    assign hit_mask = N_REQ'(1) << hit_idx;
    assign own_mask = N_REQ'(1) << own_q;

    always_comb begin
        own_want = req_want[own_i];
        own_lock = req_lock[own_i];
        own_run  = req_run[own_i];
        own_wren = req_wren[own_i];
        own_len  = req_len[own_i*16 +: 16];
        own_addr = req_addr[own_i*P_DPRAM_ADR_WIDTH +: P_DPRAM_ADR_WIDTH];
        own_data = req_data[own_i*32 +: 32];
    end

    assign fwd     = (state_q == StFill) && own_wren;
    assign wr_drop = |(req_wren & ~(fwd ? own_mask : '0));

`ifdef DPRAM_XFER_ARBITER_TIMEOUT_EN
    localparam logic [31:0] TimeoutLast = 32'(P_TIMEOUT - 1);
    logic [31:0] cnt_q;
    logic        timeout_q;
    assign host_timeout = timeout_q;
`else
    assign host_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            rr_q      <= '0;
            own_q     <= '0;
            wrote_q   <= 1'b0;
            grant_q   <= '0;
            busy_q    <= '1;
            wren_q    <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            ready_q   <= 1'b0;
            len_q     <= '0;
            src_q     <= '0;
            err_q     <= 1'b0;
`ifdef DPRAM_XFER_ARBITER_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else if (!en) begin
            state_q   <= StIdle;
            rr_q      <= '0;
            own_q     <= '0;
            wrote_q   <= 1'b0;
            grant_q   <= '0;
            busy_q    <= '1;
            wren_q    <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            ready_q   <= 1'b0;
            len_q     <= '0;
            src_q     <= '0;
            err_q     <= 1'b0;
`ifdef DPRAM_XFER_ARBITER_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            wren_q <= fwd;
            err_q  <= wr_drop;
            if (fwd) begin
                addr_q <= own_addr;
                data_q <= own_data;
            end
`ifdef DPRAM_XFER_ARBITER_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (hit) begin
                        grant_q <= hit_mask;
                        busy_q  <= ~hit_mask;
                        own_q   <= hit_idx;
                        rr_q    <= hit_idx;
                        wrote_q <= 1'b0;
                        state_q <= StFill;
                    end
                end
                StFill: begin
                    if (fwd) begin
                        wrote_q <= 1'b1;
                    end
                    if (own_run) begin
                        len_q   <= own_len;
                        src_q   <= P_SRC_WIDTH'(own_q);
                        ready_q <= 1'b1;
                        busy_q  <= '1;
                        state_q <= StHost;
`ifdef DPRAM_XFER_ARBITER_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end else if (!own_want && !wrote_q && !fwd) begin
                        // Owner withdrew before writing anything: give the slot back.
                        grant_q <= '0;
                        busy_q  <= '1;
                        state_q <= StIdle;
                    end
                end
                StHost: begin
                    if (dpram_done) begin
                        ready_q <= 1'b0;
                        state_q <= StRelease;
`ifdef DPRAM_XFER_ARBITER_TIMEOUT_EN
                    end else if (cnt_q == TimeoutLast) begin
                        timeout_q <= 1'b1;
                        ready_q   <= 1'b0;
                        grant_q   <= '0;
                        state_q   <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
`endif
                    end
                end
                StRelease: begin
                    if (own_lock && own_want) begin
                        busy_q  <= ~grant_q;
                        wrote_q <= 1'b0;
                        state_q <= StFill;
                    end else begin
                        grant_q <= '0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_busy    = busy_q;
    assign grant       = grant_q;
    assign dpram_wren  = wren_q;
    assign dpram_addr  = addr_q;
    assign dpram_data  = data_q;
    assign dpram_ready = ready_q;
    assign dpram_len   = len_q;
    assign dpram_src   = src_q;
    assign err_wr_drop = err_q;

endmodule

// File: tb/tb_dpram_xfer_arbiter.sv
// Bench for dpram_xfer_arbiter: directed handoff scenarios plus random traffic, all checked
// against a transaction-level ownership model.
module tb_dpram_xfer_arbiter;

    localparam int N  = 2;
    localparam int AW = 10;
    localparam int SW = 4;
    localparam int AddrBits = N * AW;
    localparam int LenBits  = N * 16;

    localparam int PhIdle = 0;
    localparam int PhFill = 1;
    localparam int PhHost = 2;
    localparam int PhRel  = 3;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                en;
    logic [N-1:0]        req_want;
    logic [N-1:0]        req_lock;
    logic [N-1:0]        req_run;
    logic [N*16-1:0]     req_len;
    logic [N-1:0]        req_wren;
    logic [N*AW-1:0]     req_addr;
    logic [N*32-1:0]     req_data;
    logic [N-1:0]        req_busy;
    logic [N-1:0]        grant;
    logic                dpram_wren;
    logic [AW-1:0]       dpram_addr;
    logic [31:0]         dpram_data;
    logic                dpram_ready;
    logic [15:0]         dpram_len;
    logic [SW-1:0]       dpram_src;
    logic                dpram_done;
    logic                err_wr_drop;
    logic                host_timeout;

    dpram_xfer_arbiter #(
        .N_REQ             (N),
        .P_DPRAM_ADR_WIDTH (AW),
        .P_SRC_WIDTH       (SW),
        .P_TIMEOUT         (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .req_want     (req_want),
        .req_lock     (req_lock),
        .req_run      (req_run),
        .req_len      (req_len),
        .req_wren     (req_wren),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_busy     (req_busy),
        .grant        (grant),
        .dpram_wren   (dpram_wren),
        .dpram_addr   (dpram_addr),
        .dpram_data   (dpram_data),
        .dpram_ready  (dpram_ready),
        .dpram_len    (dpram_len),
        .dpram_src    (dpram_src),
        .dpram_done   (dpram_done),
        .err_wr_drop  (err_wr_drop),
        .host_timeout (host_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Ownership model: who holds the DPRAM, which phase of the handoff it is in,
    // and what the registered outputs should show after each edge.
    int            ph;
    int            owner;
    int            rr;
    bit            wrote;
    bit            e_wren;
    bit            e_ready;
    bit            e_err;
    logic [AW-1:0] e_addr;
    logic [31:0]   e_data;
    logic [15:0]   e_len;
    logic [SW-1:0] e_src;

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        ph = PhIdle; owner = -1; rr = 0; wrote = 0;
        e_wren = 0; e_ready = 0; e_err = 0;
        e_addr = '0; e_data = '0; e_len = '0; e_src = '0;
    endtask

    task automatic model_step();
        bit           fwd;
        bit           found;
        logic [N-1:0] kept;
        if (!rst_n || !en) begin
            model_reset();
            return;
        end
        fwd    = (ph == PhFill) && req_wren[owner];
        kept   = fwd ? onehot(owner) : '0;
        e_err  = (req_wren & ~kept) != '0;
        e_wren = fwd;
        if (fwd) begin
            e_addr = req_addr[owner*AW +: AW];
            e_data = req_data[owner*32 +: 32];
        end
        case (ph)
            PhIdle: begin
                found = 0;
                for (int off = 1; off <= N; off++) begin
                    int c;
                    c = (rr + off) % N;
                    if (!found && req_want[c]) begin
                        found = 1; owner = c; rr = c; wrote = 0; ph = PhFill;
                    end
                end
            end
            PhFill: begin
                if (req_run[owner]) begin
                    e_len = req_len[owner*16 +: 16];
                    e_src = SW'(owner);
                    e_ready = 1; ph = PhHost;
                end else if (!req_want[owner] && !wrote && !fwd) begin
                    owner = -1; ph = PhIdle;
                end
                if (fwd) wrote = 1;
            end
            PhHost: begin
                if (dpram_done) begin
                    e_ready = 0; ph = PhRel;
                end
            end
            default: begin
                if (req_lock[owner] && req_want[owner]) begin
                    wrote = 0; ph = PhFill;
                end else begin
                    owner = -1; ph = PhIdle;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        logic [N-1:0] e_grant;
        logic [N-1:0] e_busy;
        e_grant = (owner < 0) ? '0 : onehot(owner);
        e_busy  = (ph == PhFill) ? ~onehot(owner) : {N{1'b1}};
        check_eq("grant", grant, e_grant);
        check_eq("req_busy", req_busy, e_busy);
        check_eq("dpram_ready", dpram_ready, e_ready);
        check_eq("dpram_wren", dpram_wren, e_wren);
        check_eq("dpram_len", dpram_len, e_len);
        check_eq("dpram_src", dpram_src, e_src);
        check_eq("err_wr_drop", err_wr_drop, e_err);
        check_eq("host_timeout", host_timeout, 1'b0);
        if (e_wren) begin
            check_eq("dpram_addr", dpram_addr, e_addr);
            check_eq("dpram_data", dpram_data, e_data);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic wait_fill(input string tag);
        int guard;
        guard = 0;
        while (req_busy == {N{1'b1}} && guard < 8) begin
            step();
            guard++;
        end
        check_eq(tag, req_busy != {N{1'b1}}, 1'b1);
    endtask

    // One full buffer: writes, run with len on the last write, done after dly cycles, release.
    task automatic do_buffer(input int words, input logic [15:0] len, input int dly,
                             input int exp_owner);
        int who;
        wait_fill("fill_wait");
        check_eq("grant_seq", grant, onehot(exp_owner));
        who = (owner < 0) ? 0 : owner;
        for (int w = 0; w < words; w++) begin
            req_wren[who] = 1'b1;
            req_addr[who*AW +: AW] = AW'(w + 16);
            req_data[who*32 +: 32] = $urandom;
            if (w == words - 1) begin
                req_run[who] = 1'b1;
                req_len[who*16 +: 16] = len;
            end
            step();
            req_wren = '0;
            req_run  = '0;
        end
        check_eq("buf_src", dpram_src, SW'(exp_owner));
        check_eq("buf_len", dpram_len, len);
        check_eq("buf_ready", dpram_ready, 1'b1);
        check_eq("busy_after_run", req_busy, {N{1'b1}});
        repeat (dly - 1) step();
        dpram_done = 1'b1;
        step();
        dpram_done = 1'b0;
        step();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; dpram_done = 1'b0;
        req_want = '0; req_lock = '0; req_run = '0; req_wren = '0;
        req_len = '0; req_addr = '0; req_data = '0;
        model_reset();
        @(negedge clk);
        compare_all();
        check_eq("reset_busy", req_busy, 2'b11);
        rst_n = 1'b1;
        step();

        // Requester 1 granted, then withdraws without writing.
        req_want = 2'b10;
        step();
        check_eq("solo_grant", grant, 2'b10);
        req_want = 2'b00;
        step();
        check_eq("withdraw_grant", grant, 2'b00);

        // Both want; owner 0 writes while requester 1 tries to write too.
        req_want = 2'b11;
        wait_fill("fill_wait0");
        check_eq("next_grant", grant, 2'b01);
        req_wren = 2'b11;
        req_addr = {AW'(7), AW'(5)};
        req_data = {32'h1234_5678, 32'hDEAD_BEEF};
        step();
        req_wren = '0;
        check_eq("mux_addr", dpram_addr, 5);
        check_eq("mux_data", dpram_data, 32'hDEAD_BEEF);
        check_eq("drop_pulse", err_wr_drop, 1'b1);
        step();
        check_eq("drop_once", err_wr_drop, 1'b0);
        do_buffer(4, 16'd4, 10, 0);

        // Round-robin alternation with want held.
        for (int b = 1; b < 4; b++) do_buffer(4, 16'd4, 10, b % 2);

        // Lock keeps requester 0 for a second buffer, then releases to 1.
        req_lock = 2'b01;
        do_buffer(2, 16'd2, 3, 0);
        check_eq("lock_grant", grant, 2'b01);
        check_eq("lock_busy", req_busy, 2'b10);
        req_lock = 2'b00;
        do_buffer(2, 16'd2, 3, 0);
        do_buffer(1, 16'd9, 2, 1);

        // Asynchronous reset in the middle of a host phase.
        wait_fill("fill_wait_rst");
        req_run  = grant;
        req_len  = {16'd3, 16'd3};
        step();
        req_run = '0;
        step();
        check_eq("host_ready", dpram_ready, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_ready", dpram_ready, 1'b0);
        check_eq("arst_grant", grant, 2'b00);
        check_eq("arst_busy", req_busy, 2'b11);
        model_reset();
        step();
        rst_n = 1'b1;
        req_want = '0;
        step();

        // Random traffic.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 15) == 0) req_want[i] = ~req_want[i];
                req_wren[i] = ($urandom_range(0, 2) == 0);
                req_run[i]  = ($urandom_range(0, 9) == 0);
            end
            req_lock   = N'($urandom);
            req_len    = LenBits'($urandom);
            req_addr   = AddrBits'($urandom);
            req_data   = {$urandom, $urandom};
            dpram_done = ($urandom_range(0, 7) == 0);
            en         = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dpram_xfer_arbiter.md
Name: dpram_xfer_arbiter

Overview:
- Shares one 32-bit host-readout DPRAM between N_REQ waveform-buffer readers.
- Grants the DPRAM write port to one reader at a time (round-robin) and muxes that reader's write bus onto the DPRAM.
- Hands the filled buffer to the host with a ready/done handshake, then releases it.
- Sits between the per-group wvb readers and the host DPRAM/register interface.

Parameters:
- N_REQ, 2: number of requesters (1..16).
- P_DPRAM_ADR_WIDTH, 10: DPRAM word-address width.
- P_SRC_WIDTH, 4: width of the source-index output.
- P_TIMEOUT, 1048576: host-phase watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  enable; low acts as a synchronous clear to the reset state
- req_want  in  N_REQ  requester i has data pending
- req_lock  in  N_REQ  requester i keeps its grant for the next buffer (multi-buffer event)
- req_run  in  N_REQ  one-cycle pulse: requester i's buffer is complete
- req_len  in  N_REQ*16  buffer length from requester i, sampled on req_run
- req_wren  in  N_REQ  write enable from requester i
- req_addr  in  N_REQ*P_DPRAM_ADR_WIDTH  write address from requester i
- req_data  in  N_REQ*32  write data from requester i
- req_busy  out  N_REQ  DPRAM unavailable to requester i
- grant  out  N_REQ  one-hot current owner; all zero when none
- dpram_wren  out  1  muxed DPRAM write enable
- dpram_addr  out  P_DPRAM_ADR_WIDTH  muxed DPRAM write address
- dpram_data  out  32  muxed DPRAM write data
- dpram_ready  out  1  buffer is full and owned by the host
- dpram_len  out  16  length latched from the owning requester
- dpram_src  out  P_SRC_WIDTH  index of the owning requester
- dpram_done  in  1  host pulse: buffer has been consumed
- err_wr_drop  out  1  one-cycle pulse: write from a non-granted requester was dropped
- host_timeout  out  1  one-cycle pulse: watchdog fired (0 without the feature)

Behaviour:
- Reset values: every output is 0 except req_busy, which is all ones. fsm=S_IDLE, rr_ptr=0.
- All outputs are registered. The write-bus mux has 1-cycle latency: req_* sampled in cycle n appears on dpram_* in cycle n+1.
- S_IDLE:
  - Search req_want starting at rr_ptr+1 mod N_REQ, wrapping around.
  - On the first hit k: grant<=onehot(k), rr_ptr<=k, go to S_FILL.
  - With no hit, stay in S_IDLE.
- S_FILL:
  - req_busy[k]=0; all other req_busy bits are 1.
  - Only requester k's writes are forwarded.
  - Any req_wren[j] with j!=k is dropped and pulses err_wr_drop.
  - On req_run[k]: latch dpram_len<=req_len[k], dpram_src<=k, set dpram_ready<=1, go to S_HOST.
  - If req_want[k] falls before any write has been forwarded in this grant: grant<=0, go to S_IDLE.
  - req_run from a non-granted requester is ignored.
- S_HOST:
  - req_busy is all ones; no writes are forwarded (dropped writes pulse err_wr_drop).
  - On dpram_done: dpram_ready<=0, go to S_RELEASE.
  - dpram_done in any other state is ignored.
- S_RELEASE (1 cycle):
  - If req_lock[k]=1 and req_want[k]=1: keep the grant, go to S_FILL.
  - Otherwise: grant<=0, go to S_IDLE.
- Handshake guarantee: req_busy is high on the cycle after req_run, so a reader waiting for busy rise→fall completes correctly.
- Simultaneous events:
  - req_run[k] together with req_wren[k]: the write is forwarded; that write is included in the buffer.
  - dpram_done in the same cycle dpram_ready is set: ignored, because the FSM is not yet in S_HOST.
- Reset or en deassertion mid-operation: immediate return to reset values. dpram_ready drops and any in-flight host phase is abandoned.
- N_REQ=1: round-robin degenerates to always granting requester 0.

Optional Feature:
- Macro: DPRAM_XFER_ARBITER_TIMEOUT_EN.
- When defined:
  - A 32-bit counter clears on entry to S_HOST and increments each S_HOST cycle.
  - When it reaches P_TIMEOUT-1 without dpram_done: pulse host_timeout, clear dpram_ready, grant<=0, go to S_IDLE (req_lock is ignored).
- When undefined: no counter is built, S_HOST waits indefinitely, and host_timeout is tied to 0.

Test Plan:
- rst_n=0 asserted asynchronously mid-S_HOST -> dpram_ready=0, grant=0, req_busy=2'b11 immediately, without waiting for a clk edge.
- N_REQ=2; req_want=2'b11 held; each owner writes 4 words then pulses run with len=4; host answers done 10 cycles after dpram_ready -> grant sequence 01,10,01,10; dpram_src alternates 0,1; dpram_len=4 each time.
- Owner 0 writes addr 5 data 0xDEADBEEF; requester 1 writes in the same cycle -> dpram_addr=5, dpram_data=0xDEADBEEF one cycle later; err_wr_drop pulses once.
- req_lock[0]=1 with req_want=2'b11 -> after done, grant stays 01 for the second buffer; with req_lock=0 it moves to 10.
- req_want[1] granted then dropped with no writes -> return to S_IDLE within 1 cycle; next grant goes to requester 0.
- With DPRAM_XFER_ARBITER_TIMEOUT_EN and P_TIMEOUT=16, no dpram_done -> host_timeout pulses 16 cycles after S_HOST entry; grant=0; arbitration resumes.
